// File: rtl/cci_mpf_req_arb_pkg.sv
// ============================================================================
// Module   : cci_mpf_req_arb_pkg
// Brief    : Shared types, Mdata tag geometry and tag helpers for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cci_mpf_req_arb_pkg;

  // Mdata geometry is fixed for the whole slice so the tag helpers stay simple.
  localparam int MDATA_W       = 16;
  localparam int MDATA_TAG_LSB = 12;
  localparam int TAG_W         = 4;

  typedef logic [TAG_W-1:0]   t_req_idx;
  typedef logic [TAG_W+7:0]   t_arb_cnt;
  typedef logic [MDATA_W-1:0] t_mdata;

  typedef enum logic [0:0] {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  function automatic t_mdata mdata_set_tag(t_mdata mdata, t_req_idx tag);
    t_mdata r;
    r = mdata;
    r[MDATA_TAG_LSB +: TAG_W] = tag;
    return r;
  endfunction

  function automatic t_mdata mdata_clr_tag(t_mdata mdata);
    return mdata_set_tag(mdata, '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cci_mpf_req_arb_if.sv
// ============================================================================
// Module   : cci_mpf_req_arb_if
// Brief    : Requester, FIU request and response signals of the arbiter.
//            stat_grants exists only when MPF_REQ_ARB_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cci_mpf_req_arb_if
  import cci_mpf_req_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 512
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*PAYLOAD_W-1:0] req_payload;
  logic [N_REQ*MDATA_W-1:0]   req_mdata;
  logic [N_REQ-1:0]           req_sop;
  logic [N_REQ-1:0]           req_eop;
  logic [N_REQ-1:0]           req_grant;
  logic                       out_valid;
  logic [PAYLOAD_W-1:0]       out_payload;
  t_mdata                     out_mdata;
  logic                       out_almostFull;
  logic                       rsp_valid;
  logic                       rsp_eop;
  t_mdata                     rsp_mdata;
  logic [N_REQ-1:0]           rsp_valid_out;
  t_mdata                     rsp_mdata_out;
  logic [N_REQ-1:0]           not_empty;
  logic                       tag_err;
`ifdef MPF_REQ_ARB_STATS_EN
  logic [N_REQ*32-1:0]        stat_grants;
`endif

  modport slave (
    input  req_valid, req_payload, req_mdata, req_sop, req_eop,
    input  out_almostFull, rsp_valid, rsp_eop, rsp_mdata,
    output req_grant, out_valid, out_payload, out_mdata,
    output rsp_valid_out, rsp_mdata_out, not_empty, tag_err
`ifdef MPF_REQ_ARB_STATS_EN
    , output stat_grants
`endif
  );

  modport master (
    output req_valid, req_payload, req_mdata, req_sop, req_eop,
    output out_almostFull, rsp_valid, rsp_eop, rsp_mdata,
    input  req_grant, out_valid, out_payload, out_mdata,
    input  rsp_valid_out, rsp_mdata_out, not_empty, tag_err
`ifdef MPF_REQ_ARB_STATS_EN
    , input stat_grants
`endif
  );

endinterface

`default_nettype wire

// File: rtl/cci_mpf_req_arb_rr_pick.sv
// ============================================================================
// Module   : cci_mpf_rr_pick
// Brief    : Round-robin picker: lowest request at or above ptr, else lowest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cci_mpf_rr_pick
  import cci_mpf_req_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  wire logic [N_REQ-1:0] req,
  input  wire t_req_idx         ptr,
  output logic [N_REQ-1:0]      grant
);

  localparam logic [N_REQ-1:0] c_one = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0] w_hi_mask;
  logic [N_REQ-1:0] w_hi_req;
  logic [N_REQ-1:0] w_sel;

  assign w_hi_mask = ~((c_one << ptr) - c_one);
  assign w_hi_req  = req & w_hi_mask;
  assign w_sel     = (|w_hi_req) ? w_hi_req : req;
  // Isolate the lowest set bit.
  assign grant     = w_sel & (~w_sel + c_one);

endmodule

`default_nettype wire

// File: rtl/cci_mpf_req_arb.sv
// ============================================================================
// Module   : cci_mpf_req_arb
// Brief    : Round-robin CCI request arbiter with Mdata tagging, per-requester
//            outstanding limits and tag-routed responses. Define
//            MPF_REQ_ARB_STATS_EN to add per-requester grant statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cci_mpf_req_arb
  import cci_mpf_req_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PAYLOAD_W  = 512,
  parameter int MAX_ACTIVE = 256
) (
  input wire logic           clk,
  input wire logic           reset,
  cci_mpf_req_arb_if.slave   arb
);

  localparam t_arb_cnt c_max_active = t_arb_cnt'(MAX_ACTIVE);
  localparam t_req_idx c_last_idx   = t_req_idx'(N_REQ - 1);

  t_arb_state           r_state, w_state_next;
  t_req_idx             r_ptr, r_lock_idx, w_winner, w_rsp_tag;
  t_arb_cnt             r_cnt [N_REQ];
  t_arb_cnt             w_cnt_next [N_REQ];
  logic [N_REQ-1:0]     w_owner, w_elig, w_req, w_grant, w_inc, w_dec, w_rsp_hit;
  logic                 w_any_grant, w_win_sop, w_win_eop, w_tag_bad, w_underflow;
  logic [PAYLOAD_W-1:0] w_sel_payload;
  t_mdata               w_sel_mdata;

  logic                 r_out_valid, r_tag_err;
  logic [PAYLOAD_W-1:0] r_out_payload;
  t_mdata               r_out_mdata, r_rsp_mdata_out;
  logic [N_REQ-1:0]     r_rsp_valid_out, r_not_empty;

  always_comb begin
    w_owner = '0;
    w_elig  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_owner[i] = (r_state == ARB_LOCKED) && (r_lock_idx == t_req_idx'(i));
      w_elig[i]  = arb.req_valid[i] && !arb.out_almostFull &&
                   ((r_cnt[i] < c_max_active) || w_owner[i]);
    end
  end

  // An open multi-flit packet excludes every other requester.
  assign w_req = (r_state == ARB_LOCKED) ? (w_elig & w_owner) : w_elig;

  cci_mpf_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign w_any_grant = |w_grant;

  always_comb begin
    w_winner      = '0;
    w_sel_payload = '0;
    w_sel_mdata   = '0;
    w_win_sop     = 1'b0;
    w_win_eop     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_winner      = t_req_idx'(i);
        w_sel_payload = arb.req_payload[i*PAYLOAD_W +: PAYLOAD_W];
        w_sel_mdata   = arb.req_mdata[i*MDATA_W +: MDATA_W];
        w_win_sop     = arb.req_sop[i];
        w_win_eop     = arb.req_eop[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_OPEN:   if (w_any_grant && w_win_sop && !w_win_eop) w_state_next = ARB_LOCKED;
      ARB_LOCKED: if (w_any_grant && w_win_eop)               w_state_next = ARB_OPEN;
      default:    w_state_next = ARB_OPEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ARB_OPEN;
      r_lock_idx <= '0;
      r_ptr      <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ARB_OPEN && w_state_next == ARB_LOCKED) r_lock_idx <= w_winner;
      if (w_any_grant && r_state == ARB_OPEN)
        r_ptr <= (w_winner == c_last_idx) ? '0 : w_winner + 1'b1;
    end
  end

  assign w_rsp_tag = arb.rsp_mdata[MDATA_TAG_LSB +: TAG_W];
  assign w_tag_bad = int'(w_rsp_tag) >= N_REQ;
  assign w_inc     = w_grant & arb.req_sop;

  always_comb begin
    w_rsp_hit   = '0;
    w_dec       = '0;
    w_underflow = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rsp_hit[i]  = (w_rsp_tag == t_req_idx'(i));
      w_dec[i]      = arb.rsp_valid && arb.rsp_eop && w_rsp_hit[i];
      w_cnt_next[i] = r_cnt[i];
      if (w_inc[i] && !w_dec[i]) begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end else if (w_dec[i] && !w_inc[i]) begin
        if (r_cnt[i] == '0) w_underflow = 1'b1;
        else                w_cnt_next[i] = r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
      r_not_empty     <= '0;
      r_tag_err       <= 1'b0;
      r_rsp_valid_out <= '0;
      r_rsp_mdata_out <= '0;
      r_out_valid     <= 1'b0;
      r_out_payload   <= '0;
      r_out_mdata     <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        r_cnt[i]       <= w_cnt_next[i];
        r_not_empty[i] <= (w_cnt_next[i] != '0);
      end
      r_tag_err       <= r_tag_err | (arb.rsp_valid && w_tag_bad) | w_underflow;
      r_rsp_valid_out <= arb.rsp_valid ? w_rsp_hit : '0;
      r_rsp_mdata_out <= mdata_clr_tag(arb.rsp_mdata);
      r_out_valid     <= w_any_grant;
      r_out_payload   <= w_sel_payload;
      r_out_mdata     <= mdata_set_tag(w_sel_mdata, w_winner);
    end
  end

  assign arb.req_grant     = w_grant;
  assign arb.out_valid     = r_out_valid;
  assign arb.out_payload   = r_out_payload;
  assign arb.out_mdata     = r_out_mdata;
  assign arb.rsp_valid_out = r_rsp_valid_out;
  assign arb.rsp_mdata_out = r_rsp_mdata_out;
  assign arb.not_empty     = r_not_empty;
  assign arb.tag_err       = r_tag_err;

`ifdef MPF_REQ_ARB_STATS_EN
  logic [31:0] r_stat [N_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (w_inc[i] && r_stat[i] != '1) r_stat[i] <= r_stat[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign arb.stat_grants[g*32 +: 32] = r_stat[g];
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cci_mpf_req_arb.sv
// ============================================================================
// Module   : tb_cci_mpf_req_arb
// Brief    : Directed bench for cci_mpf_req_arb (N_REQ=4, MAX_ACTIVE=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cci_mpf_req_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  cci_mpf_req_arb_if #(.N_REQ(4), .PAYLOAD_W(32)) bus ();

  cci_mpf_req_arb #(.N_REQ(4), .PAYLOAD_W(32), .MAX_ACTIVE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e);
    bus.req_valid = v;
    bus.req_sop   = s;
    bus.req_eop   = e;
    #1;
  endtask

  task automatic rsp(input logic v, input logic e, input logic [15:0] m);
    bus.rsp_valid = v;
    bus.rsp_eop   = e;
    bus.rsp_mdata = m;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  logic [3:0]  exp_g [5];
  logic [15:0] exp_m [5];

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_m = '{16'h0055, 16'h1155, 16'h2255, 16'h3355, 16'h0055};

    bus.req_valid      = '0;
    bus.req_sop        = '0;
    bus.req_eop        = '0;
    bus.out_almostFull = 1'b0;
    rsp(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      bus.req_payload[i*32 +: 32] = 32'hC0DE_0000 + i;
      bus.req_mdata[i*16 +: 16]   = 16'h0055 + 16'(i * 16'h0100);
    end

    // Reset values
    cyc();
    cyc();
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_rsp_valid_out", 32'(bus.rsp_valid_out), 32'h0);
    check("rst_not_empty", 32'(bus.not_empty), 32'h0);
    check("rst_tag_err", 32'(bus.tag_err), 32'h0);
    reset = 1'b0;

    // Four single-flit requesters rotate 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 4'hF, 4'hF);
      check("rr_grant", 32'(bus.req_grant), 32'(exp_g[k]));
      cyc();
      check("rr_out_valid", 32'(bus.out_valid), 32'h1);
      check("rr_out_mdata", 32'(bus.out_mdata), 32'(exp_m[k]));
    end
    check("rr_payload_last", bus.out_payload, 32'hC0DE_0000);
    check("rr_not_empty", 32'(bus.not_empty), 32'hF);
    drive(4'h0, 4'h0, 4'h0);
    check("idle_grant", 32'(bus.req_grant), 32'h0);
    cyc();
    check("idle_out_valid", 32'(bus.out_valid), 32'h0);
    pulse_reset();
    check("rst2_not_empty", 32'(bus.not_empty), 32'h0);

    // Move ptr to 1, then requester 1 holds the lock for a 4-flit packet
    drive(4'b0001, 4'b0001, 4'b0001);
    check("pre_lock_grant", 32'(bus.req_grant), 32'h1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0111, 4'b0101 | (k == 0 ? 4'b0010 : 4'b0000),
                     4'b0101 | (k == 3 ? 4'b0010 : 4'b0000));
      check("lock_grant", 32'(bus.req_grant), 32'h2);
      cyc();
      check("lock_out_mdata", 32'(bus.out_mdata), 32'h1155);
    end
    drive(4'b0101, 4'b0101, 4'b0101);
    check("post_lock_grant", 32'(bus.req_grant), 32'h4);
    cyc();
    check("post_lock_out_valid", 32'(bus.out_valid), 32'h1);

    // Backpressure for 5 cycles
    bus.out_almostFull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(4'b0101, 4'b0101, 4'b0101);
      check("af_grant", 32'(bus.req_grant), 32'h0);
      cyc();
      check("af_out_valid", 32'(bus.out_valid), 32'h0);
    end
    bus.out_almostFull = 1'b0;
    drive(4'b0101, 4'b0101, 4'b0101);
    check("af_release_grant", 32'(bus.req_grant), 32'h1);
    cyc();
    drive(4'h0, 4'h0, 4'h0);
    pulse_reset();

    // Outstanding limit of 2 on requester 0
    for (int k = 0; k < 2; k++) begin
      drive(4'b0001, 4'b0001, 4'b0001);
      check("lim_grant", 32'(bus.req_grant), 32'h1);
      cyc();
    end
    drive(4'b0001, 4'b0001, 4'b0001);
    check("lim_blocked", 32'(bus.req_grant), 32'h0);
    check("lim_not_empty", 32'(bus.not_empty), 32'h1);
    cyc();
    rsp(1'b1, 1'b1, 16'h0ABC);
    #1;
    check("lim_blocked_rsp_cycle", 32'(bus.req_grant), 32'h0);
    cyc();
    check("lim_rsp_valid_out", 32'(bus.rsp_valid_out), 32'h1);
    check("lim_rsp_mdata_out", 32'(bus.rsp_mdata_out), 32'h0ABC);
    rsp(1'b0, 1'b0, 16'h0000);
    #1;
    check("lim_unblocked", 32'(bus.req_grant), 32'h1);
    cyc();

    // Same-cycle increment and decrement on requester 2
    drive(4'b0100, 4'b0100, 4'b0100);
    check("same_pre_grant", 32'(bus.req_grant), 32'h4);
    cyc();
    rsp(1'b1, 1'b1, 16'h2345);
    drive(4'b0100, 4'b0100, 4'b0100);
    check("same_grant", 32'(bus.req_grant), 32'h4);
    cyc();
    check("same_rsp_valid_out", 32'(bus.rsp_valid_out), 32'h4);
    check("same_rsp_mdata_out", 32'(bus.rsp_mdata_out), 32'h0345);
    check("same_not_empty", 32'(bus.not_empty), 32'h5);
    drive(4'h0, 4'h0, 4'h0);
    rsp(1'b1, 1'b1, 16'h2000);
    cyc();
    check("drain2_not_empty", 32'(bus.not_empty), 32'h1);
    check("drain2_tag_err", 32'(bus.tag_err), 32'h0);
    check("drain2_rsp_valid_out", 32'(bus.rsp_valid_out), 32'h4);

    // Out-of-range tag
    rsp(1'b1, 1'b1, 16'h7001);
    cyc();
    check("bad_rsp_valid_out", 32'(bus.rsp_valid_out), 32'h0);
    check("bad_tag_err", 32'(bus.tag_err), 32'h1);
    rsp(1'b0, 1'b0, 16'h0000);
    cyc();
    cyc();
    check("bad_tag_err_sticky", 32'(bus.tag_err), 32'h1);
    check("bad_not_empty", 32'(bus.not_empty), 32'h1);
    reset = 1'b1;
    #1;
    check("async_rst_tag_err", 32'(bus.tag_err), 32'h0);
    check("async_rst_not_empty", 32'(bus.not_empty), 32'h0);
    cyc();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
